// File: rtl/regfile_pkg.sv
// Shared constants and block-write FSM encoding for the ID-stage register file.
package regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int BLK_WORDS  = 4;
    localparam int KEY_BASE   = 16;
    localparam int STATE_BASE = 20;

    typedef enum logic [1:0] {
        BLK_IDLE  = 2'd0,
        BLK_WRITE = 2'd1,
        BLK_DONE  = 2'd2
    } blk_state_e;

endpackage

// File: rtl/regfile_blk_wr.sv
// Serialising block-write engine: captures an AES block and drips it into
// the state window one word per cycle, backing off when a pipeline write
// hits the same register.
module regfile_blk_wr #(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int BLK_WORDS  = regfile_pkg::BLK_WORDS,
    parameter int STATE_BASE = regfile_pkg::STATE_BASE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        blk_valid,
    input  logic [BLK_WORDS*DATA_W-1:0] blk_data,
    input  logic                        conflict,
    output logic                        ready,
    output logic                        done,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data
);
    import regfile_pkg::*;

    localparam int CNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_WORDS - 1);

    blk_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BLK_WORDS*DATA_W-1:0] blk_q, blk_d;
    logic                        ready_q, ready_d;
    logic                        done_q, done_d;

    // Next-state logic: accept in IDLE, advance only on uncontended cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        case (state_q)
            BLK_IDLE: begin
                if (blk_valid) begin
                    blk_d   = blk_data;
                    cnt_d   = '0;
                    state_d = BLK_WRITE;
                end
            end
            BLK_WRITE: begin
                if (!conflict) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = BLK_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            BLK_DONE: state_d = BLK_IDLE;
            default:  state_d = BLK_IDLE;
        endcase
        ready_d = (state_d == BLK_IDLE);
        done_d  = (state_d == BLK_DONE);
    end

    // FSM, counter, captured block and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLK_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Current target word; word 0 sits in the MSBs of the captured block
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                wr_data = blk_q[(BLK_WORDS-1-i)*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_addr = ADDR_W'(STATE_BASE) + ADDR_W'(cnt_q);
    assign wr_en   = (state_q == BLK_WRITE) && !conflict;
    assign ready   = ready_q;
    assign done    = done_q;

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-ported ID-stage register file with hardwired $0, optional write-to-read
// bypass, AES key/state windows and a serialising block-write engine.
module id_regfile_mp #(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int BLK_WORDS  = regfile_pkg::BLK_WORDS,
    parameter int KEY_BASE   = regfile_pkg::KEY_BASE,
    parameter int STATE_BASE = regfile_pkg::STATE_BASE,
    parameter int BYPASS     = 1
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic [NUM_RD*ADDR_W-1:0]    in_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    out_rd_data,
    input  logic [NUM_WR-1:0]           in_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]    in_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    in_wr_data,
    input  logic                        in_blk_valid,
    input  logic [BLK_WORDS*DATA_W-1:0] in_blk_data,
    output logic                        out_blk_ready,
    output logic                        out_blk_done,
    output logic [BLK_WORDS*DATA_W-1:0] out_cipherkey,
    output logic [BLK_WORDS*DATA_W-1:0] out_state
);
    import regfile_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    if (STATE_BASE + BLK_WORDS > DEPTH) begin : g_bad_state_window
        $error("state window exceeds register file depth");
    end
    if (KEY_BASE + BLK_WORDS > DEPTH) begin : g_bad_key_window
        $error("key window exceeds register file depth");
    end
    if (STATE_BASE == 0) begin : g_bad_state_base
        $error("state window must not start at $0");
    end
    if (NUM_WR < 1) begin : g_bad_num_wr
        $error("at least one write port is required");
    end

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic              blk_conflict;
    logic              blk_wr_en;
    logic [ADDR_W-1:0] blk_wr_addr;
    logic [DATA_W-1:0] blk_wr_data;
    logic [ADDR_W-1:0] rd_a;

    regfile_blk_wr #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BLK_WORDS  (BLK_WORDS),
        .STATE_BASE (STATE_BASE)
    ) u_blk_wr (
        .clk       (in_clk),
        .rst       (in_rst),
        .blk_valid (in_blk_valid),
        .blk_data  (in_blk_data),
        .conflict  (blk_conflict),
        .ready     (out_blk_ready),
        .done      (out_blk_done),
        .wr_en     (blk_wr_en),
        .wr_addr   (blk_wr_addr),
        .wr_data   (blk_wr_data)
    );

    // Any enabled pipeline write to the engine's target forces it to retry
    always_comb begin
        blk_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (in_wr_en[j] && (in_wr_addr[j*ADDR_W +: ADDR_W] == blk_wr_addr)) begin
                blk_conflict = 1'b1;
            end
        end
    end

    // Next array contents: block word first, then ports in age order so the
    // youngest (highest-index) write lands last; $0 is forced back to zero
    always_comb begin
        regs_d = regs_q;
        if (blk_wr_en) begin
            regs_d[blk_wr_addr] = blk_wr_data;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (in_wr_en[j]) begin
                regs_d[in_wr_addr[j*ADDR_W +: ADDR_W]] = in_wr_data[j*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
    end

    // Register array
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: the next-state view is exactly the winning same-cycle write
    always_comb begin
        out_rd_data = '0;
        rd_a        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a = in_rd_addr[k*ADDR_W +: ADDR_W];
            if (rd_a != '0) begin
                out_rd_data[k*DATA_W +: DATA_W] = (BYPASS != 0) ? regs_d[rd_a] : regs_q[rd_a];
            end
        end
    end

    // AES windows come straight from the array, word 0 in the MSBs
    always_comb begin
        out_cipherkey = '0;
        out_state     = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            out_cipherkey[(BLK_WORDS-1-i)*DATA_W +: DATA_W] = regs_q[KEY_BASE + i];
            out_state[(BLK_WORDS-1-i)*DATA_W +: DATA_W]     = regs_q[STATE_BASE + i];
        end
    end

endmodule

// File: tb/tb_id_regfile_mp.sv
// Bench for id_regfile_mp: table vectors, block-write corner sequences and a
// randomized run against a queue-based reference model.
module tb_id_regfile_mp;

    logic         clk;
    logic         in_rst;
    logic [19:0]  rd_addr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         blk_valid;
    logic [127:0] blk_data;

    logic [127:0] rd_b, rd_nb;
    logic         ready_b, done_b, ready_nb, done_nb;
    logic [127:0] key_b, state_b, key_nb, state_nb;

    int n_tests = 0;
    int n_fail  = 0;

    id_regfile_mp #(.BYPASS(1)) u_dut_b (
        .in_clk(clk), .in_rst(in_rst),
        .in_rd_addr(rd_addr), .out_rd_data(rd_b),
        .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
        .in_blk_valid(blk_valid), .in_blk_data(blk_data),
        .out_blk_ready(ready_b), .out_blk_done(done_b),
        .out_cipherkey(key_b), .out_state(state_b)
    );

    id_regfile_mp #(.BYPASS(0)) u_dut_nb (
        .in_clk(clk), .in_rst(in_rst),
        .in_rd_addr(rd_addr), .out_rd_data(rd_nb),
        .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
        .in_blk_valid(blk_valid), .in_blk_data(blk_data),
        .out_blk_ready(ready_nb), .out_blk_done(done_nb),
        .out_cipherkey(key_nb), .out_state(state_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [4:0] a; logic [31:0] d; } pend_t;
    logic [31:0] m_mem [32];
    pend_t       m_q [$];
    bit          m_done;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_q.delete();
        m_done = 0;
    endtask

    task automatic model_check_and_step();
        logic [31:0] nxt [32];
        bit          blk_w;
        bit          found;
        logic [4:0]  ha, ra;
        logic [31:0] hd, eb;
        bit          exp_ready;
        pend_t       p;
        nxt   = m_mem;
        blk_w = 0;
        ha    = '0;
        hd    = '0;
        if (m_q.size() > 0) begin
            ha    = m_q[0].a;
            hd    = m_q[0].d;
            blk_w = 1;
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*5 +: 5] == ha) blk_w = 0;
            if (blk_w) nxt[ha] = hd;
        end
        for (int j = 0; j < 2; j++)
            if (wr_en[j]) nxt[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
        nxt[0] = '0;

        for (int k = 0; k < 4; k++) begin
            ra = rd_addr[k*5 +: 5];
            eb = m_mem[ra];
            found = 0;
            for (int j = 1; j >= 0; j--) begin
                if (!found && wr_en[j] && wr_addr[j*5 +: 5] == ra) begin
                    eb = wr_data[j*32 +: 32];
                    found = 1;
                end
            end
            if (!found && blk_w && ha == ra) eb = hd;
            if (ra == 0) eb = '0;
            chk($sformatf("rnd_rd_byp%0d", k), {96'd0, rd_b[k*32 +: 32]}, {96'd0, eb});
            chk($sformatf("rnd_rd_nobyp%0d", k), {96'd0, rd_nb[k*32 +: 32]}, {96'd0, m_mem[ra]});
        end
        exp_ready = (m_q.size() == 0) && !m_done;
        chk("rnd_ready", {127'd0, ready_b}, {127'd0, exp_ready});
        chk("rnd_done", {127'd0, done_b}, {127'd0, m_done});
        chk("rnd_ready_nb", {127'd0, ready_nb}, {127'd0, exp_ready});
        chk("rnd_done_nb", {127'd0, done_nb}, {127'd0, m_done});
        chk("rnd_state", state_b, {m_mem[20], m_mem[21], m_mem[22], m_mem[23]});
        chk("rnd_key", key_b, {m_mem[16], m_mem[17], m_mem[18], m_mem[19]});
        chk("rnd_state_nb", state_nb, {m_mem[20], m_mem[21], m_mem[22], m_mem[23]});
        chk("rnd_key_nb", key_nb, {m_mem[16], m_mem[17], m_mem[18], m_mem[19]});

        m_mem  = nxt;
        m_done = blk_w && (m_q.size() == 1);
        if (blk_w) void'(m_q.pop_front());
        if (exp_ready && blk_valid) begin
            for (int i = 0; i < 4; i++) begin
                p.a = 5'(20 + i);
                p.d = blk_data[(3-i)*32 +: 32];
                m_q.push_back(p);
            end
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 5'(16 + $urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // ---------------- block-write helper ----------------
    task automatic run_block(input logic [127:0] data, input int conf_c,
                             output int done_c, output int pulses, output int busy,
                             output logic [31:0] r21_after);
        wr_en     = 2'b00;
        blk_data  = data;
        blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0;
        done_c    = -1;
        pulses    = 0;
        busy      = 0;
        r21_after = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == conf_c) begin
                wr_en   = 2'b01;
                wr_addr = {5'd0, 5'd21};
                wr_data = {32'd0, 32'hDEADBEEF};
            end else begin
                wr_en = 2'b00;
            end
            #1;
            if (c == conf_c + 1) r21_after = state_b[95:64];
            if (ready_b) break;
            busy++;
            if (done_b) begin
                pulses++;
                if (done_c < 0) done_c = c;
            end
            cyc();
        end
        wr_en = 2'b00;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra;
        logic [31:0] exp_b;
        logic [31:0] exp_nb;
    } vec_t;

    localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    initial begin
        vec_t        vt [9];
        int          done_c, pulses, busy;
        logic [31:0] r21a;

        vt[0] = '{2'b11, 5'd5,  32'h11111111, 5'd5,  32'h22222222, 5'd5,  32'h22222222, 32'h0};
        vt[1] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  32'h22222222, 32'h22222222};
        vt[2] = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0};
        vt[3] = '{2'b10, 5'd0,  32'h0,        5'd16, 32'h1,        5'd16, 32'h1,        32'h0};
        vt[4] = '{2'b11, 5'd17, 32'h2,        5'd18, 32'h3,        5'd17, 32'h2,        32'h0};
        vt[5] = '{2'b01, 5'd19, 32'h4,        5'd0,  32'h0,        5'd19, 32'h4,        32'h0};
        vt[6] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd16, 32'h1,        32'h1};
        vt[7] = '{2'b11, 5'd7,  32'h7,        5'd0,  32'hFFFFFFFF, 5'd7,  32'h7,        32'h0};
        vt[8] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  32'h0,        32'h0};

        in_rst    = 1'b1;
        rd_addr   = {5'd20, 5'd16, 5'd5, 5'd0};
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        blk_valid = 1'b0;
        blk_data  = '0;

        // reset state
        #12 in_rst = 1'b0;
        #1;
        chk("rst_rd", rd_b, 128'd0);
        chk("rst_ready", {127'd0, ready_b}, 128'd1);
        chk("rst_done", {127'd0, done_b}, 128'd0);
        chk("rst_windows", state_b | key_b, 128'd0);
        cyc();

        // table vectors: priority, bypass, $0, key window timing
        for (int i = 0; i < 9; i++) begin
            wr_en   = vt[i].we;
            wr_addr = {vt[i].wa1, vt[i].wa0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            rd_addr = {5'd0, vt[i].ra, 10'd0};
            #1;
            chk($sformatf("tbl%0d_byp", i), {96'd0, rd_b[95:64]}, {96'd0, vt[i].exp_b});
            chk($sformatf("tbl%0d_nobyp", i), {96'd0, rd_nb[95:64]}, {96'd0, vt[i].exp_nb});
            if (i == 5) chk("tbl_key_during_write", key_b, 128'h00000001_00000002_00000003_00000000);
            if (i == 6) chk("tbl_key_after_write", key_b, 128'h00000001_00000002_00000003_00000004);
            cyc();
        end
        wr_en = '0;

        // uncontended block write
        run_block(BLK1, 0, done_c, pulses, busy, r21a);
        chk("blk_done_cycle", 128'(done_c), 128'd5);
        chk("blk_done_pulses", 128'(pulses), 128'd1);
        chk("blk_busy_cycles", 128'(busy), 128'd5);
        chk("blk_state", state_b, BLK1);

        // pipeline write collides with the engine on r21
        cyc();
        run_block(BLK1, 2, done_c, pulses, busy, r21a);
        chk("conf_r21_pipeline", {96'd0, r21a}, {96'd0, 32'hDEADBEEF});
        chk("conf_done_cycle", 128'(done_c), 128'd6);
        chk("conf_done_pulses", 128'(pulses), 128'd1);
        chk("conf_busy_cycles", 128'(busy), 128'd6);
        chk("conf_state", state_b, BLK1);

        // asynchronous reset in the middle of a transfer
        cyc();
        blk_data  = BLK2;
        blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0;
        cyc();
        cyc();
        chk("mid_two_words", state_b, {32'hA0A1A2A3, 32'hB0B1B2B3, 32'h8899AABB, 32'hCCDDEEFF});
        rd_addr = {5'd5, 5'd21, 5'd20, 5'd16};
        #2 in_rst = 1'b1;
        #1;
        chk("arst_state", state_b, 128'd0);
        chk("arst_key", key_b, 128'd0);
        chk("arst_rd", rd_b, 128'd0);
        chk("arst_ready", {127'd0, ready_b}, 128'd1);
        chk("arst_done", {127'd0, done_b}, 128'd0);
        #1 in_rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (done_b) pulses++;
        end
        chk("arst_no_done", 128'(pulses), 128'd0);
        chk("arst_ready_after", {127'd0, ready_b}, 128'd1);
        run_block(BLK2, 0, done_c, pulses, busy, r21a);
        chk("post_rst_done_cycle", 128'(done_c), 128'd5);
        chk("post_rst_state", state_b, BLK2);

        // randomized run against the reference model
        cyc();
        #1 in_rst = 1'b1;
        #1 in_rst = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            cyc();
            wr_en     = 2'($urandom_range(0, 3));
            wr_addr   = {rnd_addr(), rnd_addr()};
            wr_data   = {$urandom, $urandom};
            rd_addr   = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
            blk_valid = ($urandom_range(0, 3) == 0);
            blk_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            model_check_and_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
